// File: rtl/simd_pkg.sv
// simd_pkg: types shared by the SIMD host controller, its skid buffer and the PE
package simd_pkg;
    localparam int VEC_LANES = 4;
    localparam int LANE_W = 32;
    typedef logic [VEC_LANES-1:0][LANE_W-1:0] vec_t;
    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_A, LOAD_B, START, RUN, DRAIN, DONE} host_state_t;
    typedef enum logic [3:0] {NOOP, ADD, SUB, MUL, MAC, STORE, FETCH_A, FETCH_B} pe_op_t;
endpackage

// File: rtl/simd_skid_buf.sv
// simd_skid_buf: 2-entry valid/ready buffer absorbing the result RAM read latency
module simd_skid_buf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wp, rp, pop;
    assign out_valid = count != 2'd0;
    assign pop = out_valid && out_ready;
    assign out_data = mem[rp];
    // storage is only written on a push; the caller never pushes into a full buffer
    always_ff @(posedge clk) begin
        if (in_valid) mem[wp] <= in_data;
    end
    // pointers and occupancy; reset discards anything buffered
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= 1'b0;
            rp <= 1'b0;
            count <= 2'd0;
        end else begin
            wp <= wp ^ in_valid;
            rp <= rp ^ pop;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/simd_host_ctrl.sv
// simd_host_ctrl: load/start/run/drain sequencer for the SIMD PE (optional RUN watchdog: SIMD_RUN_TIMEOUT_EN)
module simd_host_ctrl
    import simd_pkg::*;
#(
    parameter int PC_WIDTH = 12,
    parameter int INST_LEN = 12,
    parameter int DATA_WIDTH = 32,
    parameter int PE_ELEMENTS = 4,
    parameter int DRAM_DEPTH = 256,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [PC_WIDTH:0]                      cfg_inst_count,
    input  logic [DRAM_ADDR_WIDTH:0]               cfg_vec_count,
    input  logic [DRAM_ADDR_WIDTH:0]               cfg_res_count,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [PE_ELEMENTS*DATA_WIDTH-1:0]      in_data,
    output logic                                   inst_wr_en,
    output logic [PC_WIDTH-1:0]                    inst_wr_addr,
    output logic [INST_LEN-1:0]                    inst_wr_data,
    output logic                                   ram_a_wr_en,
    output logic [DRAM_ADDR_WIDTH-1:0]             ram_a_wr_addr,
    output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] ram_a_wr_data,
    output logic                                   ram_b_wr_en,
    output logic [DRAM_ADDR_WIDTH-1:0]             ram_b_wr_addr,
    output logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] ram_b_wr_data,
    output logic                                   pe_valid,
    input  logic                                   pe_stop,
    output logic                                   ram_result_rd_en,
    output logic [DRAM_ADDR_WIDTH-1:0]             ram_result_read_addr,
    input  logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] ram_result_read_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [PE_ELEMENTS*DATA_WIDTH-1:0]      out_data,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err
);
    localparam int CW = (PC_WIDTH > DRAM_ADDR_WIDTH ? PC_WIDTH : DRAM_ADDR_WIDTH) + 1;
    localparam logic [CW-1:0] IMAX = CW'(2 ** PC_WIDTH);
    localparam logic [CW-1:0] DMAX = CW'(DRAM_DEPTH);
    host_state_t state, next;
    logic [CW-1:0] ci, cv, cr, idx, oidx, sat_i, sat_v, sat_r, cur_n;
    logic [CW-2:0] wa;
    logic [PE_ELEMENTS*DATA_WIDTH-1:0] wd;
    logic accept, in_fire, last_beat, rd_go, pend, pop;
    logic [1:0] sb_count;
    assign sat_i = (CW'(cfg_inst_count) > IMAX) ? IMAX : CW'(cfg_inst_count);
    assign sat_v = (CW'(cfg_vec_count) > DMAX) ? DMAX : CW'(cfg_vec_count);
    assign sat_r = (CW'(cfg_res_count) > DMAX) ? DMAX : CW'(cfg_res_count);
    assign cfg_ready = state == IDLE;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign accept = cfg_valid && cfg_ready;
    assign in_ready = state inside {LOAD_I, LOAD_A, LOAD_B};
    assign in_fire = in_valid && in_ready;
    assign cur_n = (state == LOAD_I) ? ci : cv;
    assign last_beat = idx == cur_n - 1'b1;
    assign pop = out_valid && out_ready;
    assign rd_go = state == DRAIN && idx < cr && ({1'b0, sb_count} + {2'b0, pend} <= {2'b0, pop} + 3'd1);
    assign ram_result_rd_en = rd_go;
    assign ram_result_read_addr = idx[DRAM_ADDR_WIDTH-1:0];
    assign out_last = out_valid && oidx == cr - 1'b1;
    assign inst_wr_addr = wa[PC_WIDTH-1:0];
    assign inst_wr_data = wd[INST_LEN-1:0];
    assign ram_a_wr_addr = wa[DRAM_ADDR_WIDTH-1:0];
    assign ram_b_wr_addr = wa[DRAM_ADDR_WIDTH-1:0];
    assign ram_a_wr_data = wd;
    assign ram_b_wr_data = wd;
`ifdef SIMD_RUN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tc;
    logic err_q;
    assign err = err_q;
    // RUN watchdog; err is sticky until the next job is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            tc <= '0;
            err_q <= 1'b0;
        end else begin
            tc <= (state == RUN) ? tc + 1'b1 : '0;
            if (accept) err_q <= 1'b0;
            else if (state == RUN && !pe_stop && tc == TMAX) err_q <= 1'b1;
        end
    end
`else
    assign err = TIMEOUT_CYCLES < 0;
`endif
    // next state: zero-count load phases are skipped, pe_stop only matters in RUN
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = (sat_i != '0) ? LOAD_I : (sat_v != '0) ? LOAD_A : START;
            LOAD_I:  if (in_fire && last_beat) next = (cv != '0) ? LOAD_A : START;
            LOAD_A:  if (in_fire && last_beat) next = LOAD_B;
            LOAD_B:  if (in_fire && last_beat) next = START;
            START:   next = RUN;
            RUN: begin
                if (pe_stop) next = (cr != '0) ? DRAIN : DONE;
`ifdef SIMD_RUN_TIMEOUT_EN
                else if (tc == TMAX) next = DONE;
`endif
            end
            DRAIN:   if (pop && out_last) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : next;
    end
    // job counts and beat/read/output indices; idx restarts at every phase change
    always_ff @(posedge clk) begin
        if (rst) begin
            ci <= '0;
            cv <= '0;
            cr <= '0;
            idx <= '0;
            oidx <= '0;
        end else begin
            if (accept) begin
                ci <= sat_i;
                cv <= sat_v;
                cr <= sat_r;
            end
            idx <= (state != next) ? '0 : idx + CW'(in_fire) + CW'(rd_go);
            oidx <= (state == DRAIN) ? oidx + CW'(pop) : '0;
        end
    end
    // registered strobes: writes one cycle after beat acceptance, pe_valid one cycle after START
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_wr_en <= 1'b0;
            ram_a_wr_en <= 1'b0;
            ram_b_wr_en <= 1'b0;
            wa <= '0;
            wd <= '0;
            pe_valid <= 1'b0;
            pend <= 1'b0;
        end else begin
            inst_wr_en <= in_fire && state == LOAD_I;
            ram_a_wr_en <= in_fire && state == LOAD_A;
            ram_b_wr_en <= in_fire && state == LOAD_B;
            wa <= idx[CW-2:0];
            wd <= in_fire ? in_data : wd;
            pe_valid <= state == START;
            pend <= rd_go;
        end
    end
    simd_skid_buf #(.W(PE_ELEMENTS*DATA_WIDTH)) u_skid (
        .clk(clk),
        .rst(rst),
        .in_valid(pend),
        .in_data(ram_result_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .count(sb_count)
    );
endmodule
